mem_io_responder: RTL and testbench

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

---
 rtl/mem_io_responder_pkg.sv | 13 +
 rtl/mem_io_responder_byte_fifo.sv | 71 +++++++
 rtl/mem_io_responder.sv | 145 ++++++++++++++
 tb/tb_mem_io_responder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_io_responder_pkg.sv
// Shared address map, RAM size and run/halt state encoding for the memory and I/O responder.
package mem_io_responder_pkg;

  localparam logic [17:0] IO_BASE  = 18'h30000;
  localparam logic [17:0] IO_CNT   = 18'h30004;
  localparam logic [17:0] RAM_SIZE = 18'h20000;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// Byte-wide circular FIFO with occupancy count and a registered near-full flag.
module byte_fifo #(
  parameter int WIDTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             i_push,
  input  logic [7:0]       i_data,
  input  logic             i_pop,
  output logic [7:0]       o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH:0]   o_count,
  output logic             o_nearFull
);

  localparam int DEPTH = 1 << WIDTH;
  localparam logic [WIDTH:0]   CNT_ONE   = (WIDTH+1)'(1);
  localparam logic [WIDTH:0]   CNT_FULL  = (WIDTH+1)'(DEPTH);
  localparam logic [WIDTH:0]   CNT_NEAR  = (WIDTH+1)'(DEPTH - 2);
  localparam logic [WIDTH-1:0] PTR_ONE   = WIDTH'(1);

  logic [7:0]       r_mem [DEPTH];
  logic [WIDTH-1:0] r_wrPtr;
  logic [WIDTH-1:0] r_rdPtr;
  logic [WIDTH:0]   r_count;
  logic             r_nearFull;
  logic             w_doPush;
  logic             w_doPop;
  logic [WIDTH:0]   w_nextCount;

  assign o_full     = (r_count == CNT_FULL);
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_data     = r_mem[r_rdPtr];
  assign o_nearFull = r_nearFull;

  // A pop frees the slot a simultaneous push needs, so a full FIFO still accepts it.
  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!o_full || w_doPop);

  always_comb begin
    w_nextCount = r_count;
    case ({w_doPush, w_doPop})
      2'b10:   w_nextCount = r_count + CNT_ONE;
      2'b01:   w_nextCount = r_count - CNT_ONE;
      default: w_nextCount = r_count;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_nearFull <= 1'b0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_ONE;
      r_count    <= w_nextCount;
      r_nearFull <= (w_nextCount >= CNT_NEAR);
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// CPU-facing byte memory: on-chip RAM, UART tx/rx registers, cycle counter snapshot and halt control.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TX_FIFO_WIDTH  = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_wdata,
  output logic [7:0]  mem_rdata,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        halted
);

  logic [7:0]  r_ram [0:(1<<RAM_ADDR_WIDTH)-1];
  logic [7:0]  r_rdata;
  logic [7:0]  r_rxHold;
  logic        r_rxValid;
  logic [31:0] r_cnt;
  logic [31:0] r_snap;
  state_t      r_state;

  state_t      w_nextState;
  logic        w_haltReq;
  logic [17:0] w_addr;
  logic        w_ramSel;
  logic        w_isRx;
  logic        w_isCnt;
  logic        w_isSnapHi;
  logic        w_rxCapture;
  logic [7:0]  w_rdNext;
  logic        w_push;
  logic [7:0]  w_pushData;
  logic        w_empty;
  logic        w_full;
  logic [TX_FIFO_WIDTH:0] w_txCount;
  logic        w_unused;

  assign w_addr     = mem_a[17:0];
  assign w_ramSel   = (w_addr < RAM_SIZE);
  assign w_isRx     = (w_addr == IO_BASE);
  assign w_isCnt    = (w_addr == IO_CNT);
  assign w_isSnapHi = (w_addr[17:2] == IO_CNT[17:2]) && (w_addr[1:0] != 2'd0);
  assign w_rxCapture = rx_valid && !r_rxValid;
  assign w_unused   = ^{mem_a[31:18], w_txCount, w_full};

  assign mem_rdata = r_rdata;
  assign rx_ready  = !r_rxValid;
  assign tx_valid  = !w_empty;
  assign halted    = (r_state == ST_HALT);

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= ST_RUN;
    else        r_state <= w_nextState;
  end

  // Only the first counter write halts; it also queues a 0x00 marker byte on tx.
  always_comb begin
    w_nextState = r_state;
    w_haltReq   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (mem_wr && w_isCnt) begin
          w_nextState = ST_HALT;
          w_haltReq   = 1'b1;
        end
      end
      ST_HALT: w_nextState = ST_HALT;
      default: w_nextState = ST_RUN;
    endcase
  end

  assign w_push     = (mem_wr && w_isRx && (mem_wdata != 8'h00)) || w_haltReq;
  assign w_pushData = w_haltReq ? 8'h00 : mem_wdata;

  always_ff @(posedge clk_in) begin
    if (mem_wr && w_ramSel) begin
      r_ram[mem_a[RAM_ADDR_WIDTH-1:0]] <= mem_wdata;
    end
  end

  always_comb begin
    w_rdNext = 8'h00;
    if (w_ramSel) begin
      w_rdNext = r_ram[mem_a[RAM_ADDR_WIDTH-1:0]];
    end else if (w_isRx) begin
      w_rdNext = r_rxValid ? r_rxHold : 8'h00;
    end else if (w_isCnt) begin
      w_rdNext = r_cnt[7:0];
    end else if (w_isSnapHi) begin
      case (w_addr[1:0])
        2'd1:    w_rdNext = r_snap[15:8];
        2'd2:    w_rdNext = r_snap[23:16];
        2'd3:    w_rdNext = r_snap[31:24];
        default: w_rdNext = 8'h00;
      endcase
    end
  end

  // A capture only happens while the holding register is empty, so it never races a read-clear.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_rdata   <= 8'h00;
      r_rxHold  <= 8'h00;
      r_rxValid <= 1'b0;
      r_cnt     <= 32'd0;
      r_snap    <= 32'd0;
    end else begin
      if (!mem_wr) r_rdata <= w_rdNext;
      if (w_rxCapture) begin
        r_rxHold  <= rx_data;
        r_rxValid <= 1'b1;
      end else if (!mem_wr && w_isRx) begin
        r_rxValid <= 1'b0;
      end
      if (r_state == ST_RUN) r_cnt <= r_cnt + 32'd1;
      if (!mem_wr && w_isCnt) r_snap <= r_cnt;
    end
  end

  byte_fifo #(
    .WIDTH (TX_FIFO_WIDTH)
  ) u_txFifo (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .i_push     (w_push),
    .i_data     (w_pushData),
    .i_pop      (tx_ready),
    .o_data     (tx_data),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_txCount),
    .o_nearFull (io_buffer_full)
  );

endmodule

// File: tb/tb_mem_io_responder.sv
// Randomized scoreboard bench for mem_io_responder against a transaction-level reference model.
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        halted;

  mem_io_responder dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .halted         (halted)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int passes = 0;

  // Reference model state, always describing the DUT between clock edges.
  logic [7:0]  mRam [int];
  logic [7:0]  mRxHold = 8'h00;
  bit          mRxV = 1'b0;
  logic [31:0] mCnt = 32'd0;
  logic [31:0] mSnap = 32'd0;
  bit          mHalted = 1'b0;
  bit          mFull = 1'b0;
  logic [7:0]  mFifo[$];
  logic [7:0]  rdExpQ[$];
  logic [7:0]  txExpQ[$];
  bit          pendingRead = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Drive one cycle, predict its effects from the address map rules, then commit after the edge.
  task automatic applyStimulus(input bit rst, input bit wr, input logic [31:0] a,
                               input logic [7:0] wd, input bit txr, input bit rxv,
                               input logic [7:0] rxd);
    int          low;
    logic [7:0]  exp;
    bit          nRxV;
    logic [7:0]  nRxHold;
    logic [31:0] nSnap;
    bit          nHalted;
    bit          pushReq;
    logic [7:0]  pushData;
    bit          pop;
    bit          accept;
    rst_in = rst; mem_wr = wr; mem_a = a; mem_wdata = wd;
    tx_ready = txr; rx_valid = rxv; rx_data = rxd;
    low = int'(a[17:0]);
    exp = 8'h00; nRxV = mRxV; nRxHold = mRxHold; nSnap = mSnap; nHalted = mHalted;
    pushReq = 1'b0; pushData = 8'h00;
    if (rst) begin
      rdExpQ.push_back(8'h00);
    end else begin
      if (!wr) begin
        if (low < 'h20000) exp = mRam.exists(low) ? mRam[low] : 8'h00;
        else if (low == 'h30000) begin
          exp = mRxV ? mRxHold : 8'h00;
          nRxV = 1'b0;
        end else if (low == 'h30004) begin
          nSnap = mCnt;
          exp = mCnt[7:0];
        end else if (low >= 'h30005 && low <= 'h30007) begin
          exp = 8'((mSnap >> (8 * (low - 'h30004))) & 32'hFF);
        end
        rdExpQ.push_back(exp);
      end else begin
        if (low < 'h20000) mRam[low] = wd;
        if (low == 'h30000 && wd != 8'h00) begin
          pushReq = 1'b1; pushData = wd;
        end
        if (low == 'h30004 && !mHalted) begin
          pushReq = 1'b1; pushData = 8'h00; nHalted = 1'b1;
        end
      end
      if (rxv && !mRxV) begin
        nRxV = 1'b1; nRxHold = rxd;
      end
    end
    pop = txr && (mFifo.size() > 0);
    accept = pushReq && ((mFifo.size() < 16) || pop);
    @(posedge clk_in);
    #1;
    if (rst) begin
      mFifo.delete(); txExpQ.delete();
      mRxV = 1'b0; mRxHold = 8'h00; mCnt = 32'd0; mSnap = 32'd0;
      mHalted = 1'b0; mFull = 1'b0;
    end else begin
      if (pop) void'(mFifo.pop_front());
      if (accept) begin
        mFifo.push_back(pushData);
        txExpQ.push_back(pushData);
      end
      if (!mHalted) mCnt = mCnt + 32'd1;
      mRxV = nRxV; mRxHold = nRxHold; mSnap = nSnap; mHalted = nHalted;
      mFull = (mFifo.size() >= 14);
    end
  endtask

  task automatic wrB(input logic [17:0] addr, input logic [7:0] d, input bit txr);
    logic [31:0] r;
    r = $urandom();
    applyStimulus(1'b0, 1'b1, {r[31:18], addr}, d, txr, 1'b0, 8'h00);
  endtask

  task automatic rdB(input logic [17:0] addr, input bit txr);
    logic [31:0] r;
    r = $urandom();
    applyStimulus(1'b0, 1'b0, {r[31:18], addr}, r[7:0], txr, 1'b0, 8'h00);
  endtask

  task automatic idle(input int n, input bit txr);
    for (int i = 0; i < n; i++) rdB(18'h20000 + 18'($urandom_range(0, 'hFFFF)), txr);
  endtask

  task automatic doReset(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 8'h00);
  endtask

  function automatic logic [17:0] ramAddr(input int i);
    return (i < 32) ? 18'(i) : 18'(32'h1FFE0 + i - 32);
  endfunction

  // Monitor: retires read results and tx bytes against the scoreboard, and checks status flags.
  always @(negedge clk_in) begin
    if (pendingRead) begin
      if (rdExpQ.size() == 0) begin
        checks++;
        $display("[TB] FAIL rd_scoreboard: read result with no expectation, got 0x%0h", mem_rdata);
      end else begin
        checkOutput("mem_rdata", 32'(mem_rdata), 32'(rdExpQ.pop_front()));
      end
    end
    pendingRead = (!mem_wr || rst_in);
    checkOutput("halted", 32'(halted), 32'(mHalted));
    checkOutput("io_buffer_full", 32'(io_buffer_full), 32'(mFull));
    checkOutput("tx_valid", 32'(tx_valid), 32'(mFifo.size() > 0));
    checkOutput("rx_ready", 32'(rx_ready), 32'(!mRxV));
    if (tx_valid && tx_ready && !rst_in) begin
      if (txExpQ.size() == 0) begin
        checks++;
        $display("[TB] FAIL tx_stream: unexpected byte 0x%0h, expected none", tx_data);
      end else begin
        checkOutput("tx_data", 32'(tx_data), 32'(txExpQ.pop_front()));
      end
    end
  end

  initial begin
    rst_in = 1'b1; mem_wr = 1'b1; mem_a = 32'h0; mem_wdata = 8'h00;
    tx_ready = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    @(posedge clk_in);
    #1;
    doReset(3);

    // Same-address write then read returns the new byte.
    wrB(18'h00010, 8'hA5, 1'b1);
    rdB(18'h00010, 1'b1);
    for (int i = 0; i < 64; i++) wrB(ramAddr(i), 8'($urandom()), 1'b1);
    for (int i = 0; i < 8; i++) rdB(ramAddr(i * 8), 1'b1);

    // Zero bytes written to the tx register are filtered out.
    wrB(18'h30000, 8'h41, 1'b1);
    wrB(18'h30000, 8'h00, 1'b1);
    wrB(18'h30000, 8'h42, 1'b1);
    idle(4, 1'b1);

    // Fill the FIFO with tx stalled, overflow once, then push+pop on a full FIFO.
    for (int i = 0; i < 17; i++) wrB(18'h30000, 8'(8'h60 + i), 1'b0);
    wrB(18'h30000, 8'h99, 1'b1);
    idle(20, 1'b1);

    // rx capture and read-clear, including a read in the capture cycle.
    applyStimulus(1'b0, 1'b0, 32'h20000, 8'h00, 1'b1, 1'b1, 8'h37);
    rdB(18'h30000, 1'b1);
    rdB(18'h30000, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h30000, 8'h00, 1'b1, 1'b1, 8'h58);
    rdB(18'h30000, 1'b1);

    // Counter snapshot roughly 100 cycles after reset, bytes read apart.
    doReset(2);
    idle(97, 1'b1);
    rdB(18'h30004, 1'b1);
    rdB(18'h30005, 1'b1);
    idle(3, 1'b1);
    rdB(18'h30006, 1'b1);
    rdB(18'h30007, 1'b1);

    for (int i = 0; i < 500; i++) begin
      int sel;
      bit txr;
      bit rxv;
      logic [31:0] r;
      logic [17:0] oa;
      sel = $urandom_range(0, 9);
      txr = ($urandom_range(0, 3) != 0);
      rxv = ($urandom_range(0, 3) == 0);
      r = $urandom();
      oa = (r[0]) ? 18'(32'h30001 + $urandom_range(0, 2)) : 18'(32'h30008 + $urandom_range(0, 'hFFF7));
      case (sel)
        0, 1: applyStimulus(1'b0, 1'b1, {r[31:18], ramAddr($urandom_range(0, 63))}, r[15:8], txr, rxv, r[23:16]);
        2, 3: applyStimulus(1'b0, 1'b0, {r[31:18], ramAddr($urandom_range(0, 63))}, 8'h00, txr, rxv, r[23:16]);
        4:    applyStimulus(1'b0, 1'b1, {r[31:18], 18'h30000}, r[2:1] == 2'b00 ? 8'h00 : r[15:8], txr, rxv, r[23:16]);
        5:    applyStimulus(1'b0, 1'b0, {r[31:18], 18'h30000}, 8'h00, txr, rxv, r[23:16]);
        6:    applyStimulus(1'b0, 1'b0, {r[31:18], 18'(32'h30004 + $urandom_range(0, 3))}, 8'h00, txr, rxv, r[23:16]);
        7:    applyStimulus(1'b0, 1'b0, {r[31:18], r[1] ? oa : 18'(32'h20000 + r[15:0])}, 8'h00, txr, rxv, r[23:16]);
        8:    applyStimulus(1'b0, 1'b1, {r[31:18], r[1] ? oa : 18'(32'h20000 + r[15:0])}, r[15:8], txr, rxv, r[23:16]);
        default: applyStimulus(1'b0, 1'b0, 32'h20000, 8'h00, txr, rxv, r[23:16]);
      endcase
    end
    idle(24, 1'b1);

    // Halt: marker byte, frozen counter, second halt ignored, RAM still live, then reset mid-stream.
    wrB(18'h30000, 8'h55, 1'b0);
    wrB(18'h30004, 8'h12, 1'b0);
    idle(5, 1'b0);
    rdB(18'h30004, 1'b0);
    idle(3, 1'b0);
    rdB(18'h30004, 1'b0);
    rdB(18'h30007, 1'b0);
    wrB(18'h30004, 8'h34, 1'b0);
    wrB(18'h30000, 8'h66, 1'b0);
    wrB(ramAddr(5), 8'h5A, 1'b0);
    rdB(ramAddr(5), 1'b0);
    idle(1, 1'b1);
    doReset(1);
    idle(6, 1'b1);
    rdB(ramAddr(5), 1'b1);
    idle(4, 1'b1);

    @(negedge clk_in);
    #1;
    checkOutput("rd_queue_drained", 32'(rdExpQ.size()), 32'd0);
    checkOutput("tx_queue_drained", 32'(txExpQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
